// File: rtl/sobel_window_3x3.sv
// -----------------------------------------------------------------------------
// sobel_window_3x3
//
// Purpose:
//   Turns a raster-order pixel stream into a registered 3x3 neighbourhood
//   window for the Sobel gradient kernel. Two full lines are kept in internal
//   line memories. A window is flagged valid only when its whole neighbourhood
//   lies inside the image. A frame-done pulse accompanies the last window of
//   each frame.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous reset, active low
//   we_i     - pixel valid; data_i is accepted on each rising edge with we_i=1
//   data_i   - pixel, raster order (left to right, top to bottom)
//   window_o - packed window; pRC at [DATA_WIDTH*(9-(3R+C))-1 -: DATA_WIDTH]
//              (p00 at the MSBs, p22 = newest pixel at the LSBs)
//   valid_o  - window_o holds a complete in-image window
//   done_o   - one-cycle pulse with the last window of a frame
//   row_o    - centre row of the window    (only with SOBEL_WINDOW_COORD_OUT_EN)
//   col_o    - centre column of the window (only with SOBEL_WINDOW_COORD_OUT_EN)
//
// Optional feature macro: SOBEL_WINDOW_COORD_OUT_EN
// -----------------------------------------------------------------------------
module sobel_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 5,
  parameter int IMG_HEIGHT = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [9*DATA_WIDTH-1:0]       window_o,
  output logic                          valid_o,
  output logic                          done_o
`ifdef SOBEL_WINDOW_COORD_OUT_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [9*DW-1:0] window_q, window_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  // Line memories are never reset: the row>=2 gate hides stale contents.
  logic [DW-1:0] line1_mem [IMG_WIDTH];
  logic [DW-1:0] line2_mem [IMG_WIDTH];

  logic at_last_col_s;
  logic at_last_row_s;

  assign at_last_col_s = (col_q == CW'(IMG_WIDTH - 1));
  assign at_last_row_s = (row_q == RW'(IMG_HEIGHT - 1));

  // Next-state logic for counters, window shift and the valid/done strobes.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    window_d = window_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (we_i) begin
      if (at_last_col_s) begin
        col_d = '0;
        if (at_last_row_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
      // Shift every row left by one column; the new right column is the
      // pixel two lines up, one line up and the incoming pixel.
      window_d = {window_q[8*DW-1 -: 2*DW], line2_mem[col_q],
                  window_q[5*DW-1 -: 2*DW], line1_mem[col_q],
                  window_q[2*DW-1 -: 2*DW], data_i};
      valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_d   = at_last_row_s && at_last_col_s;
    end else begin
      col_d    = col_q;
      row_d    = row_q;
      window_d = window_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State registers: counters, window and output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q    <= '0;
      row_q    <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Line memory update: line1 takes the new pixel, line2 takes old line1.
  always_ff @(posedge clk) begin
    if (we_i) begin
      line1_mem[col_q] <= data_i;
      line2_mem[col_q] <= line1_mem[col_q];
    end
  end

  assign window_o = window_q;
  assign valid_o  = valid_q;
  assign done_o   = done_q;

`ifdef SOBEL_WINDOW_COORD_OUT_EN
  logic [RW-1:0] row_out_q, row_out_d;
  logic [CW-1:0] col_out_q, col_out_d;

  // Centre coordinates of the window being formed (one behind the counters).
  always_comb begin
    row_out_d = row_out_q;
    col_out_d = col_out_q;
    if (we_i) begin
      row_out_d = row_q - RW'(1);
      col_out_d = col_q - CW'(1);
    end else begin
      row_out_d = row_out_q;
      col_out_d = col_out_q;
    end
  end

  // Coordinate registers, updated alongside window_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_out_q <= '0;
      col_out_q <= '0;
    end else begin
      row_out_q <= row_out_d;
      col_out_q <= col_out_d;
    end
  end

  assign row_o = row_out_q;
  assign col_o = col_out_q;
`endif

endmodule

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;

  localparam logic [9*DW-1:0] FIRST_WIN =
    {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
  localparam logic [9*DW-1:0] LAST_WIN =
    {8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25};
  localparam logic [9*DW-1:0] F2_FIRST_WIN =
    {8'd101, 8'd102, 8'd103, 8'd106, 8'd107, 8'd108, 8'd111, 8'd112, 8'd113};

  logic            clk;
  logic            rst;
  logic            we_i;
  logic [DW-1:0]   data_i;
  logic [9*DW-1:0] window_o;
  logic            valid_o;
  logic            done_o;
`ifdef SOBEL_WINDOW_COORD_OUT_EN
  logic [$clog2(H)-1:0] row_o;
  logic [$clog2(W)-1:0] col_o;
`endif

  sobel_window_3x3 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .data_i  (data_i),
    .window_o(window_o),
    .valid_o (valid_o),
    .done_o  (done_o)
`ifdef SOBEL_WINDOW_COORD_OUT_EN
    ,
    .row_o   (row_o),
    .col_o   (col_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the image as received so far, indexed by (row, col).
  logic [DW-1:0]   img [H][W];
  int              pix_cnt;
  logic            held_valid;
  logic [9*DW-1:0] held_win;
  int              held_r;
  int              held_c;
  int              n_valid;
  int              n_done;

  task automatic check_eq(input string tag, input logic [9*DW-1:0] obs,
                          input logic [9*DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window whose newest pixel is (r, c): rows r-2..r, columns c-2..c.
  function automatic logic [9*DW-1:0] model_win(input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        w = {w[8*DW-1:0], img[r-2+rr][c-2+cc]};
      end
    end
    return w;
  endfunction

  task automatic model_clear();
    pix_cnt    = 0;
    held_valid = 1'b0;
    held_win   = '0;
    held_r     = 0;
    held_c     = 0;
  endtask

  // Drive one cycle, then compare against the model just after the edge.
  task automatic step(input logic we, input logic [DW-1:0] d);
    int   r;
    int   c;
    logic ev;
    logic ed;
    we_i   = we;
    data_i = d;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ed = 1'b0;
    if (we) begin
      r = pix_cnt / W;
      c = pix_cnt % W;
      img[r][c] = d;
      ev = (r >= 2) && (c >= 2);
      ed = (pix_cnt == W * H - 1);
      pix_cnt = (pix_cnt + 1) % (W * H);
      if (ev) begin
        held_win = model_win(r, c);
        held_r   = r - 1;
        held_c   = c - 1;
      end
      held_valid = ev;
    end
    check_eq("valid", 72'(valid_o), 72'(ev));
    check_eq("done", 72'(done_o), 72'(ed));
    if (held_valid) begin
      check_eq("window", window_o, held_win);
`ifdef SOBEL_WINDOW_COORD_OUT_EN
      check_eq("row_o", 72'(row_o), 72'(held_r));
      check_eq("col_o", 72'(col_o), 72'(held_c));
`endif
    end
    if (valid_o) n_valid++;
    if (done_o) n_done++;
  endtask

  // Assert reset for two cycles (inputs kept active), checking cleared outputs.
  task automatic do_reset();
    rst    = 1'b0;
    we_i   = 1'b1;
    data_i = 8'hA5;
    #1;
    check_eq("rst_valid", 72'(valid_o), 72'd0);
    check_eq("rst_done", 72'(done_o), 72'd0);
    check_eq("rst_window", window_o, 72'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_valid", 72'(valid_o), 72'd0);
      check_eq("rst_hold_window", window_o, 72'd0);
    end
`ifdef SOBEL_WINDOW_COORD_OUT_EN
    check_eq("rst_row_o", 72'(row_o), 72'd0);
    check_eq("rst_col_o", 72'(col_o), 72'd0);
`endif
    rst  = 1'b1;
    we_i = 1'b0;
    model_clear();
    n_valid = 0;
    n_done  = 0;
  endtask

  // Feed the 1..25 frame continuously with directed first/last window checks.
  task automatic frame_1_to_25(input string tag);
    for (int i = 1; i <= W * H; i++) begin
      step(1'b1, DW'(i));
      if (i == 13) check_eq({tag, "_first_win"}, window_o, FIRST_WIN);
      if (i == 25) begin
        check_eq({tag, "_last_win"}, window_o, LAST_WIN);
        check_eq({tag, "_last_done"}, 72'(done_o), 72'd1);
      end
    end
    check_eq({tag, "_n_valid"}, 72'(n_valid), 72'd9);
    check_eq({tag, "_n_done"}, 72'(n_done), 72'd1);
  endtask

  initial begin
    rst    = 1'b0;
    we_i   = 1'b0;
    data_i = '0;
    model_clear();
    n_valid = 0;
    n_done  = 0;
    #12;

    // Continuous 1..25 frame.
    do_reset();
    frame_1_to_25("cont");
    step(1'b0, 8'h00);

    // Alternate accept/stall cycles.
    do_reset();
    for (int i = 1; i <= W * H; i++) begin
      step(1'b1, DW'(i));
      if (i == 13) check_eq("alt_first_win", window_o, FIRST_WIN);
      step(1'b0, 8'hEE);
      if (i == 13) check_eq("alt_first_hold", window_o, FIRST_WIN);
      if (i == 25) check_eq("alt_last_hold", window_o, LAST_WIN);
    end
    check_eq("alt_n_valid", 72'(n_valid), 72'd9);
    check_eq("alt_n_done", 72'(n_done), 72'd1);

    // Two back-to-back frames without an idle cycle.
    do_reset();
    for (int i = 1; i <= W * H; i++) step(1'b1, DW'(i));
    for (int i = 101; i <= 100 + W * H; i++) begin
      step(1'b1, DW'(i));
      if (i == 113) check_eq("f2_first_win", window_o, F2_FIRST_WIN);
    end
    check_eq("f2_n_valid", 72'(n_valid), 72'd18);
    check_eq("f2_n_done", 72'(n_done), 72'd2);

    // Reset mid-frame after pixel 12, then a full frame.
    do_reset();
    for (int i = 1; i <= 12; i++) step(1'b1, DW'(i));
    do_reset();
    frame_1_to_25("midrst");

    // Randomized data and accept pattern across several frames.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, DW'($urandom));
    end
    check_eq("rand_saw_valid", 72'(n_valid > 0), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Downstream neighbour of the single-line FIFO buffer stage in the Sobel edge-detection pipeline.
- Accepts a raster-order 8-bit pixel stream and keeps two full image lines internally.
- Emits a registered 3x3 pixel window with a valid strobe, one window per accepted pixel whose 3x3 neighbourhood lies fully inside the image.
- Feeds the Sobel gradient kernel directly; a frame-done pulse marks the last window of each frame.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 5, pixels per line; must be >= 3.
- IMG_HEIGHT, 5, lines per frame; must be >= 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- we_i  input  1  pixel valid; data_i is accepted on each rising edge where we_i=1.
- data_i  input  DATA_WIDTH  pixel, raster order: left to right, top to bottom.
- window_o  output  9*DATA_WIDTH  packed window; pRC (R row 0=top, C col 0=left) at bits [DATA_WIDTH*(9-(3R+C))-1 -: DATA_WIDTH]. p00 is at the MSBs and p22 (newest pixel) at the LSBs.
- valid_o  output  1  window_o holds a complete in-image window.
- done_o  output  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (rst=0, async):
  - col/row counters, window registers, valid_o and done_o clear to 0.
  - Line memories are not cleared; row gating makes their contents irrelevant.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1, width $clog2 of each dimension.
  - Both advance only on accepted pixels.
  - col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 and the next pixel starts a new frame with no idle cycle required.
- Line storage, updated on an accept at column col:
  - Reads are old values from the same address.
  - line1[col] <= data_i.
  - line2[col] <= old line1[col].
- Window shift on accept:
  - Columns 0 and 1 take the old columns 1 and 2.
  - New column 2 = {p02=old line2[col], p12=old line1[col], p22=data_i}.
- Latency: one clock. window_o and valid_o update on the same edge that accepts the pixel.
- valid_o:
  - Set to 1 on an accept with row>=2 and col>=2; otherwise 0.
  - Forced to 0 on any edge with we_i=0.
  - Never high for two windows from one pixel.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) assertions per frame.
- Stalls: with we_i=0, window_o, counters and memories hold.
- No border padding: windows that would straddle the left edge or the line wrap are suppressed by the col>=2 gate.
- done_o:
  - Set to 1 on the accept at (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the final valid_o; otherwise 0.
- Reset mid-frame: the stream restarts at (0,0) on the next accepted pixel. No stale window is flagged valid, because the row>=2 gate applies again.

Optional Feature:
- Macro: SOBEL_WINDOW_COORD_OUT_EN.
- Defined:
  - Adds output ports row_o (width $clog2(IMG_HEIGHT)) and col_o (width $clog2(IMG_WIDTH)).
  - Both are registered with window_o and give the centre-pixel coordinates (row-1, col-1) of the window.
  - Both reset to 0 and hold during stalls.
- Undefined: the ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then continuous we_i=1 with data_i=1..25 (5x5):
  - valid_o is high exactly 9 times.
  - First window follows pixel 13: p00..p22 = 1,2,3,6,7,8,11,12,13.
- Same frame, last window:
  - p00..p22 = 13,14,15,18,19,20,23,24,25.
  - done_o=1 in that cycle only, and 0 on all others.
- 1..25 with we_i low on alternate cycles:
  - Identical 9-window sequence.
  - valid_o follows only accepted pixels.
  - window_o holds during gaps.
- Frame 1..25 immediately followed by 101..125:
  - Second frame's first window = 101,102,103,106,107,108,111,112,113.
  - 18 valid windows and 2 done_o pulses in total.
- Reset (rst=0) for 2 cycles after pixel 12 (outputs 0 during reset), then 1..25 → same responses as the first scenario.
- With SOBEL_WINDOW_COORD_OUT_EN on the 1..25 frame → first window row_o=1, col_o=1; last window row_o=3, col_o=3.
